// File: rtl/vc_trace_line_sched.sv
// Line-trace scheduler: gathers fragments from NREQ sources in index order into one
// line buffer (SEP between fragments), then streams the line out terminated by '\n'.
module vc_trace_line_sched #(
  parameter int          NREQ   = 4,
  parameter int          NCHARS = 64,
  parameter logic [7:0]  SEP    = 8'h7C
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_start,
  input  logic [NREQ-1:0]   req_en,
  input  logic [NREQ-1:0]   req_val,
  output logic [NREQ-1:0]   req_rdy,
  input  logic [NREQ*8-1:0] req_char,
  input  logic [NREQ-1:0]   req_last,
  output logic              out_val,
  input  logic              out_rdy,
  output logic [7:0]        out_char,
  output logic              out_eol,
  output logic              busy,
  output logic              overflow,
  output logic [15:0]       line_cnt
);

  localparam int AW = $clog2(NCHARS);
  localparam int PW = AW + 1;
  localparam int GW = $clog2(NREQ + 1);

  typedef enum logic [2:0] {IDLE, SCAN, COLLECT, SEP_INS, DRAIN, EOL} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [NREQ-1:0] mask_q, mask_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     line_cnt_q, line_cnt_d;
  logic [NREQ-1:0] req_rdy_q, req_rdy_d;
  logic            out_val_q, out_val_d;
  logic [7:0]      out_char_q, out_char_d;
  logic            out_eol_q, out_eol_d;
  logic            busy_q, busy_d;

  logic [7:0]      line_mem [NCHARS];
  logic            wr_en;
  logic [7:0]      wr_data;
  logic [7:0]      rd_char;

  logic            cur_en, cur_last, more_en, hs_in, buf_full;
  logic [7:0]      cur_char;
  logic [NREQ-1:0] grant_sel;

  // Select the currently granted requester and look ahead for later enabled ones.
  always_comb begin
    cur_en   = 1'b0;
    cur_last = 1'b0;
    cur_char = 8'h00;
    more_en  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == GW'(i)) begin
        cur_en   = mask_q[i];
        cur_last = req_last[i];
        cur_char = req_char[8*i +: 8];
      end
      if ((GW'(i) > grant_q) && mask_q[i]) more_en = 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_sel
      assign grant_sel[gi] = (grant_d == GW'(gi));
    end
  endgenerate

  assign hs_in    = (state_q == COLLECT) && |(req_val & req_rdy_q);
  assign buf_full = (wr_ptr_q == PW'(NCHARS));
  assign rd_char  = line_mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    mask_d     = mask_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    line_cnt_d = line_cnt_q;
    out_val_d  = out_val_q;
    out_char_d = out_char_q;
    out_eol_d  = out_eol_q;
    wr_en      = 1'b0;
    wr_data    = cur_char;
    case (state_q)
      IDLE: begin
        if (line_start) begin
          mask_d     = req_en;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          overflow_d = 1'b0;
          grant_d    = '0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (grant_q == GW'(NREQ)) state_d = DRAIN;
        else if (cur_en)          state_d = COLLECT;
        else                      grant_d = grant_q + GW'(1);
      end
      COLLECT: begin
        if (hs_in) begin
          if (!buf_full) begin
            wr_en    = 1'b1;
            wr_data  = cur_char;
            wr_ptr_d = wr_ptr_q + PW'(1);
          end else begin
            overflow_d = 1'b1;
          end
          if (cur_last) begin
            grant_d = grant_q + GW'(1);
            state_d = more_en ? SEP_INS : DRAIN;
          end
        end
      end
      SEP_INS: begin
        if (!buf_full) begin
          wr_en    = 1'b1;
          wr_data  = SEP;
          wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
          overflow_d = 1'b1;
        end
        state_d = SCAN;
      end
      DRAIN: begin
        // Output register reloads only when empty or being consumed, so it holds under stall.
        if (!out_val_q || out_rdy) begin
          if (rd_ptr_q < wr_ptr_q) begin
            out_char_d = rd_char;
            out_val_d  = 1'b1;
            rd_ptr_d   = rd_ptr_q + PW'(1);
          end else begin
            out_char_d = 8'h0A;
            out_val_d  = 1'b1;
            out_eol_d  = 1'b1;
            state_d    = EOL;
          end
        end
      end
      EOL: begin
        if (out_rdy) begin
          out_val_d  = 1'b0;
          out_eol_d  = 1'b0;
          out_char_d = 8'h00;
          line_cnt_d = line_cnt_q + 16'd1;
          rd_ptr_d   = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d    = (state_d != IDLE);
    req_rdy_d = (state_d == COLLECT) ? grant_sel : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      mask_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      line_cnt_q <= 16'd0;
      req_rdy_q  <= '0;
      out_val_q  <= 1'b0;
      out_char_q <= 8'h00;
      out_eol_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      mask_q     <= mask_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      line_cnt_q <= line_cnt_d;
      req_rdy_q  <= req_rdy_d;
      out_val_q  <= out_val_d;
      out_char_q <= out_char_d;
      out_eol_q  <= out_eol_d;
      busy_q     <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) line_mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign req_rdy  = req_rdy_q;
  assign out_val  = out_val_q;
  assign out_char = out_char_q;
  assign out_eol  = out_eol_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign line_cnt = line_cnt_q;

endmodule

// File: tb/tb_vc_trace_line_sched.sv
// Scoreboard bench for vc_trace_line_sched: expected line beats are queued when a
// line is launched and popped as the sink accepts each char.
module tb_vc_trace_line_sched;

  localparam int NREQ   = 4;
  localparam int NCHARS = 8;
  localparam logic [7:0] SEP = 8'h7C;

  logic              clk = 1'b0;
  logic              reset;
  logic              line_start;
  logic [NREQ-1:0]   req_en;
  logic [NREQ-1:0]   req_val;
  logic [NREQ-1:0]   req_rdy;
  logic [NREQ*8-1:0] req_char;
  logic [NREQ-1:0]   req_last;
  logic              out_val;
  logic              out_rdy;
  logic [7:0]        out_char;
  logic              out_eol;
  logic              busy;
  logic              overflow;
  logic [15:0]       line_cnt;

  vc_trace_line_sched #(.NREQ(NREQ), .NCHARS(NCHARS), .SEP(SEP)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .req_en(req_en),
    .req_val(req_val), .req_rdy(req_rdy), .req_char(req_char), .req_last(req_last),
    .out_val(out_val), .out_rdy(out_rdy), .out_char(out_char), .out_eol(out_eol),
    .busy(busy), .overflow(overflow), .line_cnt(line_cnt)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]      frag [NREQ][16];
  int              frag_len [NREQ];
  int              frag_pos [NREQ];
  int              hs_cnt [NREQ];
  logic [8:0]      exp_q [$];
  logic [NREQ-1:0] line_en;
  bit              exp_ovf;
  bit              rand_rdy;
  bit              ls_when_busy;
  bit              eol_seen;
  bit              prev_stall;
  logic [7:0]      prev_char;
  int              rdy_err;
  int              line_cnt_exp;

  task automatic clear_frags();
    for (int i = 0; i < NREQ; i++) begin
      frag_len[i] = 0;
      frag_pos[i] = 0;
      hs_cnt[i]   = 0;
    end
  endtask

  task automatic set_frag(input int i, input string s);
    frag_len[i] = s.len();
    for (int j = 0; j < s.len() && j < 16; j++) frag[i][j] = s[j];
  endtask

  // One clock: drive inputs at negedge, observe registered outputs, record handshakes.
  task automatic step(input bit ls);
    logic [8:0] exp;
    @(negedge clk);
    line_start = ls | (ls_when_busy & busy);
    for (int i = 0; i < NREQ; i++) begin
      if (frag_pos[i] < frag_len[i]) begin
        req_val[i]          = 1'b1;
        req_char[8*i +: 8]  = frag[i][frag_pos[i]];
        req_last[i]         = (frag_pos[i] == frag_len[i] - 1);
      end else begin
        req_val[i]          = 1'b0;
        req_char[8*i +: 8]  = 8'h00;
        req_last[i]         = 1'b0;
      end
    end
    out_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    if ($countones(req_rdy) > 1 || (req_rdy & ~line_en) != '0) rdy_err++;
    if (out_eol && !out_val) rdy_err++;
    if (prev_stall) begin
      tests_run++;
      if (out_val !== 1'b1 || out_char !== prev_char) begin
        tests_failed++;
        $display("FAIL stall_hold: out_val=%b out_char=%h, required out_val=1 out_char=%h",
                 out_val, out_char, prev_char);
      end
    end
    if (out_val && out_rdy) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL out_beat: got char=%h eol=%b, required no beat", out_char, out_eol);
      end else begin
        exp = exp_q.pop_front();
        if ({out_eol, out_char} !== exp) begin
          tests_failed++;
          $display("FAIL out_beat: got char=%h eol=%b, required char=%h eol=%b",
                   out_char, out_eol, exp[7:0], exp[8]);
        end
      end
      if (out_eol) begin
        eol_seen = 1'b1;
        tests_run++;
        if (overflow !== exp_ovf) begin
          tests_failed++;
          $display("FAIL overflow_at_eol: got %b, required %b", overflow, exp_ovf);
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req_rdy[i] && req_val[i]) begin
        frag_pos[i]++;
        hs_cnt[i]++;
      end
    end
    prev_stall = out_val && !out_rdy;
    prev_char  = out_char;
  endtask

  task automatic run_line(input logic [NREQ-1:0] en, input bit rnd, input bit extra,
                          input string name);
    logic [7:0] line_q [$];
    bit first;
    int cyc;
    first = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (en[i]) begin
        if (!first) line_q.push_back(SEP);
        first = 1'b0;
        for (int j = 0; j < frag_len[i]; j++) line_q.push_back(frag[i][j]);
      end
    end
    exp_ovf = (line_q.size() > NCHARS);
    exp_q.delete();
    for (int k = 0; k < line_q.size() && k < NCHARS; k++) exp_q.push_back({1'b0, line_q[k]});
    exp_q.push_back({1'b1, 8'h0A});
    req_en = en; line_en = en; rand_rdy = rnd; ls_when_busy = extra;
    eol_seen = 1'b0; prev_stall = 1'b0; rdy_err = 0;
    for (int i = 0; i < NREQ; i++) begin frag_pos[i] = 0; hs_cnt[i] = 0; end
    step(1'b1);
    cyc = 0;
    while (!eol_seen && cyc < 400) begin
      step(1'b0);
      cyc++;
    end
    ls_when_busy = 1'b0;
    rand_rdy = 1'b0;
    tests_run++;
    if (!eol_seen) begin
      tests_failed++;
      $display("FAIL %s_timeout: no eol within 400 cycles, required eol", name);
    end
    line_cnt_exp++;
    repeat (3) step(1'b0);
    tests_run += 5;
    if (line_cnt !== 16'(line_cnt_exp)) begin
      tests_failed++;
      $display("FAIL %s_line_cnt: got %0d, required %0d", name, line_cnt, line_cnt_exp);
    end
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_busy_idle: got %b, required 0", name, busy);
    end
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_missing_beats: got %0d left, required 0", name, exp_q.size());
    end
    if (rdy_err != 0) begin
      tests_failed++;
      $display("FAIL %s_protocol: got %0d violations, required 0", name, rdy_err);
    end
    if (overflow !== exp_ovf) begin
      tests_failed++;
      $display("FAIL %s_overflow_idle: got %b, required %b", name, overflow, exp_ovf);
    end
    for (int i = 0; i < NREQ; i++) begin
      tests_run++;
      if (hs_cnt[i] != (en[i] ? frag_len[i] : 0)) begin
        tests_failed++;
        $display("FAIL %s_req%0d_handshakes: got %0d, required %0d", name, i, hs_cnt[i],
                 en[i] ? frag_len[i] : 0);
      end
    end
    $display("[TB] line %s done: %0d cycles, line_cnt=%0d", name, cyc, line_cnt);
  endtask

  task automatic check_reset_outputs(input string name);
    tests_run++;
    if (req_rdy !== '0 || out_val !== 1'b0 || out_char !== 8'h00 || out_eol !== 1'b0 ||
        busy !== 1'b0 || overflow !== 1'b0 || line_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL %s: got rdy=%b val=%b char=%h eol=%b busy=%b ovf=%b cnt=%0d, required all 0",
               name, req_rdy, out_val, out_char, out_eol, busy, overflow, line_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    line_start = 1'b0; req_en = '0; req_val = '0; req_char = '0; req_last = '0;
    out_rdy = 1'b1; line_en = '0; ls_when_busy = 1'b0; rand_rdy = 1'b0;
    prev_stall = 1'b0; line_cnt_exp = 0;
    clear_frags();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_values");
    reset = 1'b1;
    step(1'b0);
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_basic();
    clear_frags();
    set_frag(0, "ab"); set_frag(1, "zz"); set_frag(2, "c"); set_frag(3, "yy");
    run_line(4'b0101, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_empty();
    clear_frags();
    set_frag(1, "q");
    run_line(4'b0000, 1'b0, 1'b0, "empty");
  endtask

  task automatic test_overflow();
    clear_frags();
    set_frag(0, "0123456789");
    run_line(4'b0001, 1'b0, 1'b0, "overflow");
    clear_frags();
    run_line(4'b0000, 1'b0, 1'b0, "overflow_cleared");
  endtask

  task automatic test_stall();
    clear_frags();
    set_frag(0, "abc");
    run_line(4'b0001, 1'b1, 1'b0, "stall");
    clear_frags();
    set_frag(1, "de"); set_frag(3, "fgh");
    run_line(4'b1010, 1'b1, 1'b0, "stall_sep");
  endtask

  task automatic test_reset_mid();
    int cnt;
    clear_frags();
    set_frag(0, "abcdef");
    req_en = 4'b0001; line_en = 4'b0001;
    exp_q.delete();
    step(1'b1);
    cnt = 0;
    while (hs_cnt[0] < 2 && cnt < 50) begin
      step(1'b0);
      cnt++;
    end
    tests_run++;
    if (hs_cnt[0] < 2) begin
      tests_failed++;
      $display("FAIL reset_mid_wait: got %0d handshakes, required 2", hs_cnt[0]);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_reset_outputs("reset_mid_same_cycle");
    @(negedge clk);
    reset = 1'b1;
    line_cnt_exp = 0;
    clear_frags();
    set_frag(0, "xy");
    run_line(4'b0001, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_ignore_start();
    clear_frags();
    set_frag(0, "pq"); set_frag(1, "rs");
    run_line(4'b0011, 1'b0, 1'b1, "ignore_start");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_overflow();
    test_stall();
    test_reset_mid();
    test_ignore_start();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
